imem_fetch: RTL
===============

Name: imem_fetch

Overview:
- Parametrised instruction memory with a fetch handshake for the MIPS core's IF stage.
- Takes byte-addressed PCs on a valid/ready request channel and returns instruction words on a valid/ready response channel after a configurable read latency.
- Adds a program-load write port, flush of in-flight fetches, and alignment/range fault reporting.

Parameters:
IM_DEPTH, 64, number of instruction words stored (power of two, >= 2)
INSTRUCTION_WIDTH, 32, bits per instruction word
ADDR_WIDTH, 32, width of byte-addressed PC
READ_LATENCY, 1, cycles from request acceptance to response valid (legal 1..3)
NOP_WORD, 32'h00000000, word returned on fault and at reset (sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  fetch request present
req_ready  out  1  fetch request can be accepted this cycle
req_pc  in  ADDR_WIDTH  byte address of instruction
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_instr  out  INSTRUCTION_WIDTH  fetched word, or NOP_WORD on fault
rsp_pc  out  ADDR_WIDTH  PC of the response
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
flush  in  1  discard all in-flight fetches
ld_en  in  1  program-load write enable
ld_addr  in  $clog2(IM_DEPTH)  word index to write
ld_data  in  INSTRUCTION_WIDTH  word to write

Behaviour:
- One clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset asserted:
  - All pipeline stage valids clear.
  - rsp_valid=0, rsp_instr=NOP_WORD, rsp_pc=0, rsp_fault=00.
  - In-flight fetches are dropped.
  - Memory contents are not affected by reset. Power-up contents are all NOP_WORD.
- stall = rsp_valid && !rsp_ready.
- req_ready = !stall && !flush && !ld_en. This is combinational, with no dependence on req_valid.
- Accept: req_valid && req_ready at a rising edge. The array is read in the acceptance cycle.
- Read data, PC and fault travel through a READ_LATENCY-deep register pipeline.
- A write landing after acceptance never alters that fetch's data.
- Latency: a request accepted at edge T gives rsp_valid high after edge T+READ_LATENCY-1, i.e. visible in cycle T+READ_LATENCY when there is no stall.
- Throughput: one per cycle.
- While stall is high:
  - The whole pipeline holds.
  - Response outputs stay stable.
  - No request is accepted.
- Word index = req_pc[ADDR_WIDTH-1:2].
- Fault rules, evaluated at acceptance:
  - req_pc[1:0]!=0 gives fault 01.
  - Otherwise, word index >= IM_DEPTH gives fault 10.
  - Misaligned has priority over out of range.
  - A faulting request returns rsp_instr=NOP_WORD with rsp_pc=req_pc.
  - It still occupies a slot and still requires a handshake.
- flush:
  - Clears every stage valid at the next edge. rsp_valid is low the cycle after flush.
  - Takes priority over stall and over rsp_ready; a response held under stall is discarded.
  - req_ready is low during flush, so no request is accepted that cycle.
- Load:
  - ld_en writes ld_data to word ld_addr at the edge.
  - req_ready is low while ld_en is high, so load and fetch never collide.
  - A fetch accepted the cycle after a write sees the new data.
- Out-of-range ld_addr cannot occur (width-limited).
- Reset mid-stall or mid-flush: reset wins and all state clears immediately.

Decomposition:
- Package imem_pkg:
  - fault_e enum: FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - MIPS_NOP constant.
  - Per-stage struct {valid, pc, instr, fault}.
- Sub-module imem_array:
  - Storage only: sync write port, combinational read port.
  - Parameters IM_DEPTH and INSTRUCTION_WIDTH.
  - Power-up initialisation to NOP_WORD.
- imem_fetch holds the handshake, fault decode, flush and pipeline registers.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> req_ready observable, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=00; release -> no spurious response.
- Load/fetch, READ_LATENCY=2: load words 0..3 = 00A62020, 00A62022, 20E8FFF6, 01063824, then fetch pc 0,4,8,12 back-to-back -> rsp_valid from 2 cycles after first accept, four consecutive responses, matching data/pc, fault 00.
- Backpressure: rsp_ready=0 for 3 cycles with 2 in flight -> rsp_* stable, req_ready=0; release -> both delivered in order, none lost or duplicated.
- Faults, IM_DEPTH=64: pc=0x6 -> fault 01, instr 0; pc=0x100 -> fault 10, instr 0; pc=0x102 -> fault 01 (priority).
- Flush: flush with 2 in flight while stalled -> rsp_valid=0 next cycle, neither response delivered; next request accepted normally.
- Load interlock and reset mid-op: ld_en=1 with req_valid=1 -> req_ready=0; word 5 written to 0xDEADBEEF; fetch pc 0x14 next cycle -> DEADBEEF. rst_n pulse with one fetch in flight -> rsp_valid never asserts for it.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared types and constants for the instruction-memory fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    // sll $0,$0,0
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Stage fields are sized for the widest supported PC / instruction word.
    localparam int c_stage_pc_w    = 32;
    localparam int c_stage_instr_w = 32;

    typedef struct packed {
        logic                       valid;
        logic [c_stage_pc_w-1:0]    pc;
        logic [c_stage_instr_w-1:0] instr;
        fault_e                     fault;
    } fetch_stage_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module   : imem_array
// Brief    : Instruction storage, synchronous write and combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int                           IM_DEPTH          = 64,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           IDX_WIDTH         = $clog2(IM_DEPTH),
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = '0
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [IDX_WIDTH-1:0]         i_waddr,
    input  logic [INSTRUCTION_WIDTH-1:0] i_wdata,
    input  logic [IDX_WIDTH-1:0]         i_raddr,
    output logic [INSTRUCTION_WIDTH-1:0] o_rdata
);

    // Contents survive reset; the declaration value gives the power-up image.
    logic [INSTRUCTION_WIDTH-1:0] r_mem [IM_DEPTH] = '{default: NOP_WORD};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch
// Brief    : IF-stage instruction memory with valid/ready fetch handshake.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch
    import imem_pkg::*;
#(
    parameter int                           IM_DEPTH          = 64,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           ADDR_WIDTH        = 32,
    parameter int                           READ_LATENCY      = 1,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = INSTRUCTION_WIDTH'(MIPS_NOP)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_pc,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [INSTRUCTION_WIDTH-1:0]  rsp_instr,
    output logic [ADDR_WIDTH-1:0]         rsp_pc,
    output logic [1:0]                    rsp_fault,
    input  logic                          flush,
    input  logic                          ld_en,
    input  logic [$clog2(IM_DEPTH)-1:0]   ld_addr,
    input  logic [INSTRUCTION_WIDTH-1:0]  ld_data
);

    localparam int                    c_idx_w  = $clog2(IM_DEPTH);
    localparam int                    c_last   = READ_LATENCY - 1;
    localparam logic [ADDR_WIDTH-3:0] c_depth  = (ADDR_WIDTH-2)'(IM_DEPTH);

    localparam fetch_stage_t c_stage_idle = '{
        valid: 1'b0,
        pc:    '0,
        instr: c_stage_instr_w'(NOP_WORD),
        fault: FAULT_NONE
    };

    logic                         w_stall;
    logic                         w_accept;
    logic [ADDR_WIDTH-3:0]        w_word_idx;
    logic [INSTRUCTION_WIDTH-1:0] w_rdata;
    fetch_stage_t                 w_stage_in;
    fetch_stage_t                 r_pipe [READ_LATENCY];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_stall    = r_pipe[c_last].valid && !rsp_ready;
    assign req_ready  = !w_stall && !flush && !ld_en;
    assign w_accept   = req_valid && req_ready;
    assign w_word_idx = req_pc[ADDR_WIDTH-1:2];

    imem_array #(
        .IM_DEPTH          (IM_DEPTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .IDX_WIDTH         (c_idx_w),
        .NOP_WORD          (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .i_we    (ld_en),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (w_word_idx[c_idx_w-1:0]),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Fault decode and stage-0 capture; misalignment outranks range.
    // ------------------------------------------------------------------
    always_comb begin
        w_stage_in       = c_stage_idle;
        w_stage_in.valid = w_accept;
        w_stage_in.pc    = c_stage_pc_w'(req_pc);
        if (req_pc[1:0] != 2'b00) begin
            w_stage_in.fault = FAULT_MISALIGN;
        end else if (w_word_idx >= c_depth) begin
            w_stage_in.fault = FAULT_RANGE;
        end else begin
            w_stage_in.fault = FAULT_NONE;
            w_stage_in.instr = c_stage_instr_w'(w_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: flush beats stall, stall freezes every stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= c_stage_idle;
            end
        end else if (flush) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i].valid <= 1'b0;
            end
        end else if (!w_stall) begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign rsp_valid = r_pipe[c_last].valid;
    assign rsp_instr = INSTRUCTION_WIDTH'(r_pipe[c_last].instr);
    assign rsp_pc    = ADDR_WIDTH'(r_pipe[c_last].pc);
    assign rsp_fault = r_pipe[c_last].fault;

endmodule : imem_fetch
`default_nettype wire
